// File: rtl/cpu_mem_pkg.sv
// Shared types and constants for the accumulator CPU memory responder.
// Opcode constants exist so benches can assemble program words.
package cpu_mem_pkg;

  localparam int unsigned ADDR_W_DEF = 5;
  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned MEM_DEPTH  = 2 ** ADDR_W_DEF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2,
    LOAD = 2'd3
  } state_e;

  localparam logic [2:0] OP_HLT = 3'd0;
  localparam logic [2:0] OP_LDA = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_SUB = 3'd3;
  localparam logic [2:0] OP_AND = 3'd4;
  localparam logic [2:0] OP_STO = 3'd5;
  localparam logic [2:0] OP_JZ  = 3'd6;
  localparam logic [2:0] OP_JMP = 3'd7;

  // Instruction word layout is opcode[7:5] | operand[4:0].
  function automatic logic [7:0] asm_word(input logic [2:0] op, input logic [4:0] operand);
    return {op, operand};
  endfunction

endpackage

// File: rtl/cpu_mem_responder_if.sv
// Request/response channel bundle between the CPU (master) and the memory responder (slave).
interface cpu_mem_responder_if #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 8
);

  logic              REQ_VALID;
  logic              REQ_READY;
  logic              REQ_WE;
  logic [ADDR_W-1:0] REQ_ADDR;
  logic [DATA_W-1:0] REQ_WDATA;
  logic              RSP_VALID;
  logic              RSP_READY;
  logic [DATA_W-1:0] RSP_DATA;
  logic              RSP_ERR;

  modport master (
    output REQ_VALID, REQ_WE, REQ_ADDR, REQ_WDATA, RSP_READY,
    input  REQ_READY, RSP_VALID, RSP_DATA, RSP_ERR
  );

  modport slave (
    input  REQ_VALID, REQ_WE, REQ_ADDR, REQ_WDATA, RSP_READY,
    output REQ_READY, RSP_VALID, RSP_DATA, RSP_ERR
  );

endinterface

// File: rtl/cpu_mem_array.sv
// Word storage: synchronous write, combinational read. Memory is never reset.
// With CPU_MEM_PARITY_EN defined, each word carries an even-parity bit checked on read.
module cpu_mem_array
  import cpu_mem_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              CLK,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
`ifdef CPU_MEM_PARITY_EN
  input  logic              winj,
  output logic              rerr,
`endif
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [Depth];

  always_ff @(posedge CLK) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

`ifdef CPU_MEM_PARITY_EN
  logic par [Depth];

  // Stored bit makes the total ones count even; winj flips it to plant an error.
  always_ff @(posedge CLK) begin
    if (we) begin
      par[waddr] <= (^wdata) ^ winj;
    end
  end

  assign rerr = (^rdata) ^ par[raddr];
`endif

endmodule

// File: rtl/cpu_mem_responder.sv
// Memory responder for the accumulator CPU: valid/ready request and response channels,
// programmable read wait states, sequential program load. Parity option: CPU_MEM_PARITY_EN.
module cpu_mem_responder
  import cpu_mem_pkg::*;
#(
  parameter int unsigned ADDR_W      = ADDR_W_DEF,
  parameter int unsigned DATA_W      = DATA_W_DEF,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic              CLK,
  input  logic              RST_N,
  cpu_mem_responder_if.slave bus,
  input  logic              LOAD_EN,
  input  logic              LOAD_VALID,
  input  logic [DATA_W-1:0] LOAD_DATA,
`ifdef CPU_MEM_PARITY_EN
  input  logic              PERR_INJ,
`endif
  output logic              LOAD_DONE,
  output logic              BUSY
);

  localparam logic [3:0] WaitInit = 4'(WAIT_CYCLES);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic [ADDR_W-1:0] load_ptr_q, load_ptr_d;
  logic              load_done_q, load_done_d;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic [ADDR_W-1:0] mem_raddr;
  logic [DATA_W-1:0] mem_rdata;

`ifdef CPU_MEM_PARITY_EN
  logic rsp_err_q, rsp_err_d;
  logic mem_rerr;
`endif

  cpu_mem_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_array (
    .CLK   (CLK),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (mem_wdata),
`ifdef CPU_MEM_PARITY_EN
    .winj  (PERR_INJ),
    .rerr  (mem_rerr),
`endif
    .raddr (mem_raddr),
    .rdata (mem_rdata)
  );

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    cnt_d       = cnt_q;
    rsp_data_d  = rsp_data_q;
    load_ptr_d  = load_ptr_q;
    load_done_d = load_done_q;
    mem_we      = 1'b0;
    mem_waddr   = bus.REQ_ADDR;
    mem_wdata   = bus.REQ_WDATA;
    mem_raddr   = addr_q;
`ifdef CPU_MEM_PARITY_EN
    rsp_err_d   = rsp_err_q;
`endif

    unique case (state_q)
      IDLE: begin
        // Read straight from the request address so zero-wait reads capture at accept.
        mem_raddr = bus.REQ_ADDR;
        if (LOAD_EN) begin
          state_d     = LOAD;
          load_ptr_d  = '0;
          load_done_d = 1'b0;
        end else if (bus.REQ_VALID) begin
          if (bus.REQ_WE) begin
            mem_we     = 1'b1;
            rsp_data_d = bus.REQ_WDATA;
`ifdef CPU_MEM_PARITY_EN
            rsp_err_d  = 1'b0;
`endif
            state_d    = RESP;
          end else begin
            addr_d = bus.REQ_ADDR;
            if (WAIT_CYCLES == 0) begin
              rsp_data_d = mem_rdata;
`ifdef CPU_MEM_PARITY_EN
              rsp_err_d  = mem_rerr;
`endif
              state_d    = RESP;
            end else begin
              cnt_d   = WaitInit;
              state_d = WAIT;
            end
          end
        end
      end

      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          rsp_data_d = mem_rdata;
`ifdef CPU_MEM_PARITY_EN
          rsp_err_d  = mem_rerr;
`endif
          state_d    = RESP;
        end
      end

      RESP: begin
        if (bus.RSP_READY) begin
          state_d = IDLE;
        end
      end

      LOAD: begin
        if (LOAD_VALID) begin
          mem_we     = 1'b1;
          mem_waddr  = load_ptr_q;
          mem_wdata  = LOAD_DATA;
          load_ptr_d = load_ptr_q + {{(ADDR_W - 1){1'b0}}, 1'b1};
          if (&load_ptr_q) begin
            load_done_d = 1'b1;
          end
        end
        // A strobe in the cycle LOAD_EN drops is still written above.
        if (!LOAD_EN) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      cnt_q       <= '0;
      rsp_data_q  <= '0;
      load_ptr_q  <= '0;
      load_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
      rsp_data_q  <= rsp_data_d;
      load_ptr_q  <= load_ptr_d;
      load_done_q <= load_done_d;
    end
  end

`ifdef CPU_MEM_PARITY_EN
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rsp_err_q <= 1'b0;
    end else begin
      rsp_err_q <= rsp_err_d;
    end
  end

  assign bus.RSP_ERR = rsp_err_q;
`else
  assign bus.RSP_ERR = 1'b0;
`endif

  assign bus.REQ_READY = (state_q == IDLE) && !LOAD_EN;
  assign bus.RSP_VALID = (state_q == RESP);
  assign bus.RSP_DATA  = rsp_data_q;
  assign LOAD_DONE     = load_done_q;
  assign BUSY          = (state_q != IDLE);

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Self-checking bench for cpu_mem_responder with three read wait states.
// Parity checks are included when CPU_MEM_PARITY_EN is defined.
module tb_cpu_mem_responder;
  import cpu_mem_pkg::*;

  localparam int unsigned WaitCycles = 3;
  localparam int NumVec = 8;

  typedef struct packed {
    logic       we;
    logic [4:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp;
  } vec_t;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic       LOAD_EN;
  logic       LOAD_VALID;
  logic [7:0] LOAD_DATA;
  logic       LOAD_DONE;
  logic       BUSY;
`ifdef CPU_MEM_PARITY_EN
  logic       PERR_INJ;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  vec_t vecs [NumVec];

  cpu_mem_responder_if #(.ADDR_W(5), .DATA_W(8)) bus ();

  cpu_mem_responder #(
    .ADDR_W      (5),
    .DATA_W      (8),
    .WAIT_CYCLES (WaitCycles)
  ) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .bus        (bus.slave),
    .LOAD_EN    (LOAD_EN),
    .LOAD_VALID (LOAD_VALID),
    .LOAD_DATA  (LOAD_DATA),
`ifdef CPU_MEM_PARITY_EN
    .PERR_INJ   (PERR_INJ),
`endif
    .LOAD_DONE  (LOAD_DONE),
    .BUSY       (BUSY)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Issue one request at a negedge; returns response data/err and cycles to RSP_VALID (-1 on timeout).
  task automatic txn(input logic we, input logic [4:0] addr, input logic [7:0] wdata,
                     output logic [7:0] data, output logic err, output int lat);
    bus.REQ_VALID = 1'b1;
    bus.REQ_WE    = we;
    bus.REQ_ADDR  = addr;
    bus.REQ_WDATA = wdata;
    @(negedge CLK);
    bus.REQ_VALID = 1'b0;
    lat = 1;
    while (!bus.RSP_VALID && lat < 40) begin
      @(negedge CLK);
      lat++;
    end
    if (!bus.RSP_VALID) lat = -1;
    data = bus.RSP_DATA;
    err  = bus.RSP_ERR;
    bus.RSP_READY = 1'b1;
    @(negedge CLK);
    bus.RSP_READY = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d;
    logic       e;
    int         lat;
    int         k;

    vecs[0] = '{we: 1'b0, addr: 5'd0,  wdata: 8'h00, exp: 8'hA0};
    vecs[1] = '{we: 1'b0, addr: 5'd31, wdata: 8'h00, exp: 8'hBF};
    vecs[2] = '{we: 1'b1, addr: 5'd17, wdata: 8'h3C, exp: 8'h3C};
    vecs[3] = '{we: 1'b0, addr: 5'd17, wdata: 8'h00, exp: 8'h3C};
    vecs[4] = '{we: 1'b0, addr: 5'd5,  wdata: 8'h00, exp: 8'hA5};
    vecs[5] = '{we: 1'b1, addr: 5'd9,  wdata: asm_word(OP_STO, 5'd17), exp: 8'hB1};
    vecs[6] = '{we: 1'b0, addr: 5'd9,  wdata: 8'h00, exp: 8'hB1};
    vecs[7] = '{we: 1'b0, addr: 5'd16, wdata: 8'h00, exp: 8'hB0};

    RST_N         = 1'b0;
    LOAD_EN       = 1'b0;
    LOAD_VALID    = 1'b0;
    LOAD_DATA     = 8'h00;
    bus.REQ_VALID = 1'b0;
    bus.REQ_WE    = 1'b0;
    bus.REQ_ADDR  = 5'd0;
    bus.REQ_WDATA = 8'h00;
    bus.RSP_READY = 1'b0;
`ifdef CPU_MEM_PARITY_EN
    PERR_INJ      = 1'b0;
`endif

    @(negedge CLK);
    check("reset req_ready", 32'(bus.REQ_READY), 32'd1);
    check("reset rsp_valid", 32'(bus.RSP_VALID), 32'd0);
    check("reset rsp_data",  32'(bus.RSP_DATA),  32'd0);
    check("reset rsp_err",   32'(bus.RSP_ERR),   32'd0);
    check("reset load_done", 32'(LOAD_DONE),     32'd0);
    check("reset busy",      32'(BUSY),          32'd0);
    RST_N = 1'b1;
    @(negedge CLK);

    // Program load: 32 words of addr ^ 0xA0
    LOAD_EN = 1'b1;
    #1 check("load_en blocks req_ready", 32'(bus.REQ_READY), 32'd0);
    @(negedge CLK);
    check("load busy", 32'(BUSY), 32'd1);
    for (int i = 0; i < 32; i++) begin
      LOAD_VALID = 1'b1;
      LOAD_DATA  = 8'(i) ^ 8'hA0;
      @(negedge CLK);
      if (i == 30) check("load_done before last", 32'(LOAD_DONE), 32'd0);
    end
    check("load_done after last", 32'(LOAD_DONE), 32'd1);
    LOAD_VALID = 1'b0;
    LOAD_EN    = 1'b0;
    @(negedge CLK);
    check("load exit busy", 32'(BUSY), 32'd0);
    check("load_done held", 32'(LOAD_DONE), 32'd1);

    for (int i = 0; i < NumVec; i++) begin
      txn(vecs[i].we, vecs[i].addr, vecs[i].wdata, d, e, lat);
      check($sformatf("vec%0d data", i), 32'(d), 32'(vecs[i].exp));
      check($sformatf("vec%0d latency", i), 32'(lat), vecs[i].we ? 32'd1 : 32'(1 + WaitCycles));
      if (!vecs[i].we) check($sformatf("vec%0d err", i), 32'(e), 32'd0);
    end

    // Read latency and response hold under back-pressure
    bus.REQ_VALID = 1'b1;
    bus.REQ_WE    = 1'b0;
    bus.REQ_ADDR  = 5'd5;
    #1 check("hold req_ready idle", 32'(bus.REQ_READY), 32'd1);
    @(negedge CLK);
    bus.REQ_VALID = 1'b0;
    for (int i = 0; i < WaitCycles; i++) begin
      check("wait rsp_valid low", 32'(bus.RSP_VALID), 32'd0);
      check("wait req_ready low", 32'(bus.REQ_READY), 32'd0);
      @(negedge CLK);
    end
    check("latency rsp_valid", 32'(bus.RSP_VALID), 32'd1);
    check("latency rsp_data", 32'(bus.RSP_DATA), 32'hA5);
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      check("held rsp_valid", 32'(bus.RSP_VALID), 32'd1);
      check("held rsp_data", 32'(bus.RSP_DATA), 32'hA5);
      check("held req_ready", 32'(bus.REQ_READY), 32'd0);
    end
    bus.RSP_READY = 1'b1;
    @(negedge CLK);
    bus.RSP_READY = 1'b0;
    check("post-handshake rsp_valid", 32'(bus.RSP_VALID), 32'd0);
    check("post-handshake req_ready", 32'(bus.REQ_READY), 32'd1);

    // Reset while a read is waiting
    bus.REQ_VALID = 1'b1;
    bus.REQ_ADDR  = 5'd17;
    @(negedge CLK);
    bus.REQ_VALID = 1'b0;
    check("pre-reset busy", 32'(BUSY), 32'd1);
    RST_N = 1'b0;
    #1;
    check("midreset rsp_valid", 32'(bus.RSP_VALID), 32'd0);
    check("midreset req_ready", 32'(bus.REQ_READY), 32'd1);
    check("midreset load_done", 32'(LOAD_DONE), 32'd0);
    check("midreset busy", 32'(BUSY), 32'd0);
    @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
    txn(1'b0, 5'd17, 8'h00, d, e, lat);
    check("after reset data 17", 32'(d), 32'h3C);

    // REQ_VALID and LOAD_EN together: load wins, strobe on LOAD_EN fall still lands
    bus.REQ_VALID = 1'b1;
    bus.REQ_ADDR  = 5'd3;
    LOAD_EN       = 1'b1;
    #1 check("collide req_ready", 32'(bus.REQ_READY), 32'd0);
    @(negedge CLK);
    check("collide busy", 32'(BUSY), 32'd1);
    check("collide rsp_valid", 32'(bus.RSP_VALID), 32'd0);
    bus.REQ_VALID = 1'b0;
    LOAD_EN       = 1'b0;
    LOAD_VALID    = 1'b1;
    LOAD_DATA     = 8'h5A;
    @(negedge CLK);
    LOAD_VALID = 1'b0;
    check("collide exit busy", 32'(BUSY), 32'd0);
    check("collide no response", 32'(bus.RSP_VALID), 32'd0);
    txn(1'b0, 5'd0, 8'h00, d, e, lat);
    check("last-strobe data 0", 32'(d), 32'h5A);

    // LOAD_EN during WAIT: read finishes, then load is entered
    bus.REQ_VALID = 1'b1;
    bus.REQ_ADDR  = 5'd31;
    @(negedge CLK);
    bus.REQ_VALID = 1'b0;
    LOAD_EN       = 1'b1;
    k = 0;
    while (!bus.RSP_VALID && k < 20) begin
      @(negedge CLK);
      k++;
    end
    check("wait-load rsp_valid", 32'(bus.RSP_VALID), 32'd1);
    check("wait-load rsp_data", 32'(bus.RSP_DATA), 32'hBF);
    bus.RSP_READY = 1'b1;
    @(negedge CLK);
    bus.RSP_READY = 1'b0;
    check("wait-load idle busy", 32'(BUSY), 32'd0);
    check("wait-load req_ready", 32'(bus.REQ_READY), 32'd0);
    @(negedge CLK);
    check("wait-load enters load", 32'(BUSY), 32'd1);
    LOAD_EN = 1'b0;
    @(negedge CLK);
    check("wait-load exit", 32'(BUSY), 32'd0);

`ifdef CPU_MEM_PARITY_EN
    PERR_INJ = 1'b1;
    txn(1'b1, 5'd2, 8'h01, d, e, lat);
    PERR_INJ = 1'b0;
    check("parity write echo", 32'(d), 32'h01);
    txn(1'b0, 5'd2, 8'h00, d, e, lat);
    check("parity bad data", 32'(d), 32'h01);
    check("parity bad err", 32'(e), 32'd1);
    txn(1'b1, 5'd2, 8'h01, d, e, lat);
    txn(1'b0, 5'd2, 8'h00, d, e, lat);
    check("parity good data", 32'(d), 32'h01);
    check("parity good err", 32'(e), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_mem_responder.md
Name: cpu_mem_responder

Overview:
External 32x8 memory responder for the accumulator CPU. It serves fetch, operand-read and store requests over a valid/ready request channel and returns data on a valid/ready response channel. Read latency is programmable. A sequential program-load port fills memory before the CPU is released.

Parameters:
ADDR_W, 5, address width; depth is 2**ADDR_W words
DATA_W, 8, word width (opcode[7:5] | operand[4:0])
WAIT_CYCLES, 1, extra wait states between read accept and response (0..15)

Ports:
CLK  in  1  clock, rising edge
RST_N  in  1  asynchronous active-low reset
REQ_VALID  in  1  request present
REQ_READY  out  1  responder can accept a request
REQ_WE  in  1  1 = write (STO), 0 = read (fetch/operand)
REQ_ADDR  in  ADDR_W  word address
REQ_WDATA  in  DATA_W  write data
RSP_VALID  out  1  response present
RSP_READY  in  1  requester accepts response
RSP_DATA  out  DATA_W  read data; for writes, echo of the written data
RSP_ERR  out  1  parity error flag, qualified by RSP_VALID
LOAD_EN  in  1  program-load mode request
LOAD_VALID  in  1  load word strobe
LOAD_DATA  in  DATA_W  load word
LOAD_DONE  out  1  all 2**ADDR_W words loaded
BUSY  out  1  state != IDLE

Behaviour:
- Reset (async, RST_N low): state IDLE, REQ_READY=1, RSP_VALID=0, RSP_DATA=0, RSP_ERR=0, LOAD_DONE=0, load pointer=0, wait counter=0. Memory contents are not reset.
- FSM states: IDLE, WAIT, RESP, LOAD.
- IDLE:
  - REQ_READY = !LOAD_EN.
  - Accept occurs on REQ_VALID && REQ_READY at the rising edge.
  - Write accept: mem[REQ_ADDR] <= REQ_WDATA at the accept edge; RSP_DATA <= REQ_WDATA; go to RESP.
  - Read accept: latch address. If WAIT_CYCLES=0, go directly to RESP with RSP_DATA = mem[addr]. Otherwise load the counter with WAIT_CYCLES and go to WAIT.
  - LOAD_EN=1 (takes priority over REQ_VALID in the same cycle): go to LOAD, pointer <= 0, LOAD_DONE <= 0.
- WAIT: counter decrements each cycle. When it reaches 1, capture mem[addr] into RSP_DATA and go to RESP. Read latency from accept edge to RSP_VALID high = 1 + WAIT_CYCLES cycles.
- RESP:
  - RSP_VALID=1; RSP_DATA and RSP_ERR are held stable until RSP_READY.
  - On RSP_VALID && RSP_READY: RSP_VALID <= 0, go to IDLE. The next request can be accepted on the following cycle (no same-cycle turnaround).
- Single outstanding transaction: REQ_READY=0 in WAIT, RESP and LOAD.
- Read data reflects all writes completed before the read was accepted.
- LOAD:
  - Each cycle with LOAD_VALID: mem[ptr] <= LOAD_DATA, ptr <= ptr+1 (wraps modulo depth).
  - Writing word depth-1 sets LOAD_DONE=1. LOAD_DONE stays high until the next entry into LOAD or reset.
  - Further strobes after wrap overwrite from address 0; LOAD_DONE stays 1.
  - LOAD_EN falling: go to IDLE on the next edge. A LOAD_VALID in that same cycle is still written.
- LOAD_EN raised in WAIT/RESP is ignored until the transaction completes and the FSM returns to IDLE.
- Reset mid-transaction discards any pending response. Writes already committed remain in memory.
- Out-of-range values cannot occur, since the address is exactly ADDR_W bits.

Optional Feature:
CPU_MEM_PARITY_EN
- Defined:
  - Each word stores an extra even-parity bit computed on write and load.
  - Reads recompute parity; on mismatch, RSP_ERR=1 with RSP_VALID.
  - Adds input PERR_INJ (1 bit). When high on a write or load, the stored parity bit is inverted.
- Undefined: no parity storage, RSP_ERR tied 0, PERR_INJ port absent.

Decomposition:
- Package cpu_mem_pkg:
  - ADDR_W/DATA_W defaults and MEM_DEPTH
  - state enum (IDLE, WAIT, RESP, LOAD)
  - opcode constants HLT..JMP, for bench program assembly
- One sub-module, cpu_mem_array:
  - synchronous-write, combinational-read storage with one write port muxed between request and load
  - parity bit generation/check under CPU_MEM_PARITY_EN

Test Plan:
- Load: LOAD_EN=1, 32 LOAD_VALID strobes of data=addr^8'hA0 -> LOAD_DONE rises after the 32nd write. Reads of addr 0, 31 return 8'hA0, 8'hBF.
- Read latency: WAIT_CYCLES=3, read addr 5 accepted at cycle t -> RSP_VALID at t+4 with RSP_DATA=mem[5]. Hold RSP_READY=0 for 3 cycles -> RSP_VALID and RSP_DATA stay stable. REQ_READY stays 0 until the cycle after the handshake.
- Write then read: write 8'h3C to addr 17 -> RSP echoes 8'h3C. A following read of addr 17 returns 8'h3C.
- Priority/collision: REQ_VALID and LOAD_EN rise in the same IDLE cycle -> no request accepted, BUSY=1, state LOAD. LOAD_EN raised during WAIT -> the read completes first, then LOAD is entered.
- Reset mid-op: assert RST_N=0 during WAIT -> RSP_VALID=0, REQ_READY=1, LOAD_DONE=0 immediately. Earlier-written data is still readable.
- Parity (macro defined): write 8'h01 to addr 2 with PERR_INJ=1 -> read returns 8'h01 with RSP_ERR=1. Rewrite with PERR_INJ=0 -> RSP_ERR=0.
